// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM state encoding, mode
// selectors and the width helper used to size the Stein shift counter.
package gcd_pkg;

  typedef enum logic [1:0] {
    GCD_IDLE,
    GCD_CALC,
    GCD_DONE
  } gcd_state_t;

  localparam logic GCD_MODE_EUCLID = 1'b0;
  localparam logic GCD_MODE_STEIN  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gcd_dp.sv
// GCD datapath: operand/shift registers plus one Euclid or Stein step per
// enabled cycle. done_o flags the terminating condition, result_o the answer.
module gcd_dp
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;

  assign diff_ab = a_q - b_q;
  assign diff_ba = b_q - a_q;

  assign done_o   = (mode_q == GCD_MODE_EUCLID) ? (b_q == '0)
                                                : ((a_q == '0) || (b_q == '0));
  // Stein result re-applies the common factor of two stripped off earlier.
  assign result_o = (mode_q == GCD_MODE_EUCLID) ? a_q : ((a_q | b_q) << k_q);

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    k_d    = k_q;
    mode_d = mode_q;
    if (load_i) begin
      a_d    = a_i;
      b_d    = b_i;
      k_d    = '0;
      mode_d = mode_i;
    end else if (step_i && !done_o) begin
      if (mode_q == GCD_MODE_EUCLID) begin
        if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else begin
          a_d = diff_ab;
        end
      end else begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q >= b_q) begin
          a_d = diff_ab >> 1;
        end else begin
          b_d = diff_ba >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      mode_q <= GCD_MODE_EUCLID;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      k_q    <= k_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: IDLE/CALC/DONE handshake FSM, saturating CALC-cycle counter
// and result registers that only change on entry to DONE.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             mode,
  input  logic             input_ready,
  output logic             input_available,
  output logic             result_rdy,
  input  logic             result_taken,
  output logic [WIDTH-1:0] result_data,
  output logic [CNT_W-1:0] result_cycles,
  output logic             result_err
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  gcd_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_pend_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cycles_q;
  logic             err_q;

  logic             dp_load;
  logic             dp_step;
  logic             dp_done;
  logic [WIDTH-1:0] dp_result;

  assign dp_load = (state_q == GCD_IDLE) && input_ready;
  assign dp_step = (state_q == GCD_CALC);
  assign cnt_d   = sat_inc(cnt_q);

  // Handshake flags depend on state alone, never on the requesting inputs.
  assign input_available = (state_q == GCD_IDLE);
  assign result_rdy      = (state_q == GCD_DONE);
  assign result_data     = data_q;
  assign result_cycles   = cycles_q;
  assign result_err      = err_q;

  gcd_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .mode_i   (mode),
    .a_i      (operand_A),
    .b_i      (operand_B),
    .done_o   (dp_done),
    .result_o (dp_result)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= GCD_IDLE;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      data_q     <= '0;
      cycles_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        GCD_IDLE: begin
          if (input_ready) begin
            cnt_q      <= '0;
            err_pend_q <= (operand_A == '0) && (operand_B == '0);
            state_q    <= GCD_CALC;
          end
        end
        GCD_CALC: begin
          cnt_q <= cnt_d;
          if (dp_done) begin
            data_q   <= dp_result;
            cycles_q <= cnt_d;
            err_q    <= err_pend_q;
            state_q  <= GCD_DONE;
          end
        end
        GCD_DONE: begin
          if (result_taken) begin
            state_q <= GCD_IDLE;
          end
        end
        default: state_q <= GCD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and table-driven bench for gcd_engine (WIDTH=16): both algorithms,
// zero operands, backpressure, asynchronous reset mid-calculation.
module tb_gcd_engine;

  localparam int WIDTH = 16;
  localparam int CNT_W = WIDTH + 1;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [WIDTH-1:0] operand_A;
  logic [WIDTH-1:0] operand_B;
  logic             mode;
  logic             input_ready;
  logic             input_available;
  logic             result_rdy;
  logic             result_taken;
  logic [WIDTH-1:0] result_data;
  logic [CNT_W-1:0] result_cycles;
  logic             result_err;

  always #5 sys_clk = ~sys_clk;

  gcd_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .operand_A       (operand_A),
    .operand_B       (operand_B),
    .mode            (mode),
    .input_ready     (input_ready),
    .input_available (input_available),
    .result_rdy      (result_rdy),
    .result_taken    (result_taken),
    .result_data     (result_data),
    .result_cycles   (result_cycles),
    .result_err      (result_err)
  );

  typedef struct {
    string            name;
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] c;
    logic             e;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic run_txn(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int limit, output logic [WIDTH-1:0] d, output logic [CNT_W-1:0] c,
                         output logic e, output int lat, output bit ok);
    int w;
    ok  = 1'b1;
    lat = 0;
    d   = '0;
    c   = '0;
    e   = 1'b0;
    @(negedge sys_clk);
    w = 0;
    while (!input_available && w < limit) begin
      @(negedge sys_clk);
      w++;
    end
    if (!input_available) begin
      ok = 1'b0;
      return;
    end
    operand_A   = a;
    operand_B   = b;
    mode        = m;
    input_ready = 1'b1;
    @(posedge sys_clk);
    #1 input_ready = 1'b0;
    @(negedge sys_clk);
    while (!result_rdy && lat < limit) begin
      lat++;
      @(negedge sys_clk);
    end
    if (!result_rdy) begin
      ok = 1'b0;
      return;
    end
    d = result_data;
    c = result_cycles;
    e = result_err;
    result_taken = 1'b1;
    @(posedge sys_clk);
    #1 result_taken = 1'b0;
  endtask

  task automatic wait_rdy(input int limit, output bit ok);
    int w;
    w = 0;
    while (!result_rdy && w < limit) begin
      @(negedge sys_clk);
      w++;
    end
    ok = result_rdy;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             vecs[13];
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] c;
    logic             e;
    int               lat;
    bit               ok;
    bit               stable;
    logic [WIDTH-1:0] ra, rb;

    // name, mode, A, B, gcd, CALC cycles, err
    vecs[0]  = '{"euc_48_18",  1'b0, 16'd48,    16'd18, 16'd6, 17'd9,  1'b0};
    vecs[1]  = '{"stn_48_18",  1'b1, 16'd48,    16'd18, 16'd6, 17'd7,  1'b0};
    vecs[2]  = '{"stn_0_5",    1'b1, 16'd0,     16'd5,  16'd5, 17'd1,  1'b0};
    vecs[3]  = '{"euc_0_5",    1'b0, 16'd0,     16'd5,  16'd5, 17'd2,  1'b0};
    vecs[4]  = '{"euc_0_0",    1'b0, 16'd0,     16'd0,  16'd0, 17'd1,  1'b1};
    vecs[5]  = '{"stn_0_0",    1'b1, 16'd0,     16'd0,  16'd0, 17'd1,  1'b1};
    vecs[6]  = '{"euc_5_0",    1'b0, 16'd5,     16'd0,  16'd5, 17'd1,  1'b0};
    vecs[7]  = '{"stn_5_0",    1'b1, 16'd5,     16'd0,  16'd5, 17'd1,  1'b0};
    vecs[8]  = '{"euc_7_7",    1'b0, 16'd7,     16'd7,  16'd7, 17'd3,  1'b0};
    vecs[9]  = '{"stn_7_7",    1'b1, 16'd7,     16'd7,  16'd7, 17'd2,  1'b0};
    vecs[10] = '{"stn_8_4",    1'b1, 16'd8,     16'd4,  16'd4, 17'd5,  1'b0};
    vecs[11] = '{"euc_8_4",    1'b0, 16'd8,     16'd4,  16'd4, 17'd4,  1'b0};
    vecs[12] = '{"stn_1_ffff", 1'b1, 16'd1,  16'd65535, 16'd1, 17'd17, 1'b0};

    sys_rst_n    = 1'b0;
    operand_A    = '0;
    operand_B    = '0;
    mode         = 1'b0;
    input_ready  = 1'b0;
    result_taken = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset available", input_available, 1);
    check("reset rdy", result_rdy, 0);
    check("reset data", result_data, 0);
    check("reset cycles", result_cycles, 0);
    check("reset err", result_err, 0);
    sys_rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].m, vecs[i].a, vecs[i].b, 2000, d, c, e, lat, ok);
      check($sformatf("%s completed", vecs[i].name), ok, 1);
      check($sformatf("%s data", vecs[i].name), d, vecs[i].d);
      check($sformatf("%s cycles", vecs[i].name), c, vecs[i].c);
      check($sformatf("%s err", vecs[i].name), e, vecs[i].e);
      check($sformatf("%s latency", vecs[i].name), lat, vecs[i].c);
    end

    // Backpressure: Stein 48,18 held in DONE while the producer keeps asking.
    @(negedge sys_clk);
    operand_A   = 16'd48;
    operand_B   = 16'd18;
    mode        = 1'b1;
    input_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    operand_A = 16'd100;
    operand_B = 16'd75;
    mode      = 1'b0;
    @(negedge sys_clk);
    wait_rdy(200, ok);
    check("bp reached done", ok, 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (result_data != 16'd6 || result_cycles != 17'd7 || result_err != 1'b0 ||
          input_available != 1'b0 || result_rdy != 1'b1) stable = 1'b0;
    end
    check("bp outputs stable", stable, 1);
    result_taken = 1'b1;
    @(posedge sys_clk);
    #1 result_taken = 1'b0;
    @(negedge sys_clk);
    check("bp idle after take", input_available, 1);
    @(negedge sys_clk);
    check("bp accept next edge", input_available, 0);
    input_ready = 1'b0;
    wait_rdy(200, ok);
    check("bp second done", ok, 1);
    check("bp second data", result_data, 25);
    check("bp second cycles", result_cycles, 7);
    result_taken = 1'b1;
    @(posedge sys_clk);
    #1 result_taken = 1'b0;

    // Asynchronous reset in the middle of a long Euclid run.
    @(negedge sys_clk);
    operand_A   = 16'hFFFF;
    operand_B   = 16'd1;
    mode        = 1'b0;
    input_ready = 1'b1;
    @(posedge sys_clk);
    #1 input_ready = 1'b0;
    repeat (20) @(negedge sys_clk);
    check("rst still calc", input_available, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst async available", input_available, 1);
    check("rst async rdy", result_rdy, 0);
    check("rst async data", result_data, 0);
    check("rst async cycles", result_cycles, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst idle after release", input_available, 1);
    check("rst no stale result", result_rdy, 0);

    // Random operands checked against a modulo-based reference gcd.
    for (int i = 0; i < 16; i++) begin
      if (i[0]) begin
        ra = 16'($urandom_range(0, 65535));
        rb = 16'($urandom_range(0, 65535));
      end else begin
        ra = 16'($urandom_range(512, 65535));
        rb = 16'($urandom_range(512, 65535));
      end
      run_txn(i[0], ra, rb, 5000, d, c, e, lat, ok);
      check($sformatf("rnd%0d completed", i), ok, 1);
      check($sformatf("rnd%0d data (%0d,%0d)", i, ra, rb), d, ref_gcd(int'(ra), int'(rb)));
      check($sformatf("rnd%0d err", i), e, (ra == 0 && rb == 0) ? 1 : 0);
    end

    // 65534 subtractions reach (1,1), one more gives (0,1), then a swap and the terminating step.
    run_txn(1'b0, 16'hFFFF, 16'd1, 70000, d, c, e, lat, ok);
    check("long completed", ok, 1);
    check("long data", d, 1);
    check("long cycles", c, 65537);
    check("long latency", lat, 65537);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
